// File: rtl/uart_cmd_sequencer_if.sv
// Transceiver-side handshake bundle for the UART command sequencer.
// master: sequencer (consumes commands, produces reply bytes).
// slave : UART transceiver (holds pending command, serialises reply bytes).
interface uart_cmd_sequencer_if;
    logic        cmd_rdy;      // complete 24-bit command pending
    logic [23:0] cmd;          // [23:16] opcode, [15:8] address, [7:0] data
    logic        clr_cmd_rdy;  // one-cycle pulse: command consumed
    logic        trmt;         // one-cycle pulse: start sending tx_data
    logic [7:0]  tx_data;      // reply byte, stable from trmt until tx_done
    logic        tx_done;      // byte finished; dropped by transceiver after trmt

    modport master (
        input  cmd_rdy, cmd, tx_done,
        output clr_cmd_rdy, trmt, tx_data
    );

    modport slave (
        output cmd_rdy, cmd, tx_done,
        input  clr_cmd_rdy, trmt, tx_data
    );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// Decodes 24-bit UART commands into config register writes/reads and sequences the reply bytes.
// Latency: clr_cmd_rdy 1 cycle after the accepting edge, first trmt 2 cycles after it.
// Backpressure: a new command waits (cmd_rdy left set) until the previous reply has fully drained.
// Ports: clk, rst_n; xcvr (transceiver handshake, master side); cfg0..cfg3 config registers;
//        cfg_wr/cfg_wr_addr write strobe and index; busy while not IDLE.
module uart_cmd_sequencer #(
    parameter logic [7:0] ACK_BYTE = 8'hA5,
    parameter logic [7:0] NAK_BYTE = 8'hEE,
    parameter logic [7:0] CFG_RST  = 8'h00
) (
    input  logic                        clk,
    input  logic                        rst_n,
    uart_cmd_sequencer_if.master        xcvr,
    output logic [7:0]                  cfg0,
    output logic [7:0]                  cfg1,
    output logic [7:0]                  cfg2,
    output logic [7:0]                  cfg3,
    output logic                        cfg_wr,
    output logic [1:0]                  cfg_wr_addr,
    output logic                        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        WAIT_TX = 2'd2
    } state_t;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_READ2 = 8'h03;

    state_t      state_q, state_d;
    logic [23:0] cmd_q, cmd_d;
    logic        idle_ok_q, idle_ok_d;   // IDLE has lasted at least one full cycle
    logic [1:0]  guard_q, guard_d;       // cycles left during which tx_done is stale
    logic        pend2_q, pend2_d;       // second READ2 byte still to send
    logic [7:0]  byte2_q, byte2_d;
    logic [7:0]  cfg_q [4];
    logic [7:0]  cfg_d [4];
    logic        clr_q, clr_d;
    logic        trmt_q, trmt_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        cfg_wr_q, cfg_wr_d;
    logic [1:0]  cfg_wr_addr_q, cfg_wr_addr_d;

    // Command decode, always from the latched copy.
    logic [7:0] op, addr, wdat;
    logic [1:0] idx, idx_nxt;
    logic       addr_ok, is_wr, is_rd, is_rd2, accept, tx_ack;

    assign op      = cmd_q[23:16];
    assign addr    = cmd_q[15:8];
    assign wdat    = cmd_q[7:0];
    assign idx     = addr[1:0];
    assign idx_nxt = idx + 2'd1;          // READ2 wraps 3 -> 0
    assign addr_ok = (addr[7:2] == 6'd0);
    assign is_wr   = addr_ok && (op == OP_WRITE);
    assign is_rd   = addr_ok && (op == OP_READ);
    assign is_rd2  = addr_ok && (op == OP_READ2);

    assign accept  = (state_q == IDLE) && idle_ok_q && xcvr.cmd_rdy;
    // tx_done is still high from the previous byte during the trmt cycle and the one after.
    assign tx_ack  = (state_q == WAIT_TX) && (guard_q == 2'd0) && xcvr.tx_done;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cmd_q         <= 24'd0;
            idle_ok_q     <= 1'b0;
            guard_q       <= 2'd0;
            pend2_q       <= 1'b0;
            byte2_q       <= 8'h00;
            clr_q         <= 1'b0;
            trmt_q        <= 1'b0;
            tx_data_q     <= 8'h00;
            cfg_wr_q      <= 1'b0;
            cfg_wr_addr_q <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                cfg_q[i] <= CFG_RST;
            end
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            idle_ok_q     <= idle_ok_d;
            guard_q       <= guard_d;
            pend2_q       <= pend2_d;
            byte2_q       <= byte2_d;
            clr_q         <= clr_d;
            trmt_q        <= trmt_d;
            tx_data_q     <= tx_data_d;
            cfg_wr_q      <= cfg_wr_d;
            cfg_wr_addr_q <= cfg_wr_addr_d;
            for (int i = 0; i < 4; i++) begin
                cfg_q[i] <= cfg_d[i];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = WAIT_TX;
            WAIT_TX: if (tx_ack && !pend2_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        cmd_d         = accept ? xcvr.cmd : cmd_q;
        idle_ok_d     = (state_q == IDLE) && (state_d == IDLE);
        guard_d       = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;
        pend2_d       = pend2_q;
        byte2_d       = byte2_q;
        clr_d         = 1'b0;
        trmt_d        = 1'b0;
        tx_data_d     = tx_data_q;
        cfg_wr_d      = 1'b0;
        cfg_wr_addr_d = cfg_wr_addr_q;
        for (int i = 0; i < 4; i++) begin
            cfg_d[i] = cfg_q[i];
        end

        case (state_q)
            IDLE: begin
                clr_d = accept;
            end
            EXEC: begin
                trmt_d  = 1'b1;
                guard_d = 2'd2;
                pend2_d = is_rd2;
                byte2_d = cfg_q[idx_nxt];
                if (is_wr) begin
                    tx_data_d     = ACK_BYTE;
                    cfg_d[idx]    = wdat;
                    cfg_wr_d      = 1'b1;
                    cfg_wr_addr_d = idx;
                end else if (is_rd || is_rd2) begin
                    tx_data_d = cfg_q[idx];
                end else begin
                    tx_data_d = NAK_BYTE;
                end
            end
            WAIT_TX: begin
                if (tx_ack && pend2_q) begin
                    trmt_d    = 1'b1;
                    guard_d   = 2'd2;
                    tx_data_d = byte2_q;
                    pend2_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign xcvr.clr_cmd_rdy = clr_q;
    assign xcvr.trmt        = trmt_q;
    assign xcvr.tx_data     = tx_data_q;
    assign cfg0             = cfg_q[0];
    assign cfg1             = cfg_q[1];
    assign cfg2             = cfg_q[2];
    assign cfg3             = cfg_q[3];
    assign cfg_wr           = cfg_wr_q;
    assign cfg_wr_addr      = cfg_wr_addr_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Testbench for uart_cmd_sequencer: transceiver model plus reply/write scoreboard.
// Latency: n/a.
// Backpressure: model holds cmd_rdy until clr_cmd_rdy; tx_done drops one cycle after trmt.
module tb_uart_cmd_sequencer;

    localparam logic [7:0] ACK  = 8'hA5;
    localparam logic [7:0] NAK  = 8'hEE;
    localparam logic [7:0] CRST = 8'h00;
    localparam int         TX_LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cfg0, cfg1, cfg2, cfg3;
    logic       cfg_wr;
    logic [1:0] cfg_wr_addr;
    logic       busy;
    logic [7:0] cfg_obs [4];

    always #5 clk = ~clk;

    uart_cmd_sequencer_if u_if ();

    uart_cmd_sequencer #(
        .ACK_BYTE (ACK),
        .NAK_BYTE (NAK),
        .CFG_RST  (CRST)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .xcvr        (u_if.master),
        .cfg0        (cfg0),
        .cfg1        (cfg1),
        .cfg2        (cfg2),
        .cfg3        (cfg3),
        .cfg_wr      (cfg_wr),
        .cfg_wr_addr (cfg_wr_addr),
        .busy        (busy)
    );

    assign cfg_obs[0] = cfg0;
    assign cfg_obs[1] = cfg1;
    assign cfg_obs[2] = cfg2;
    assign cfg_obs[3] = cfg3;

    int checks   = 0;
    int failures = 0;
    int n_cmd    = 0;
    int n_byte   = 0;
    int clr_cnt  = 0;
    int trmt_cnt = 0;
    bit tx_busy  = 1'b0;

    logic [7:0] rsp_q [$];
    logic [1:0] wa_q  [$];
    logic [7:0] wd_q  [$];
    logic [7:0] cfg_m [4];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Transceiver model and output monitor, sampled 1 time unit after each rising edge.
    initial begin
        int  cnt;
        bit  clr_next, prev_clr, prev_busy, prev_trmt;
        logic [7:0] exp_b;
        logic [1:0] exp_a;
        logic [7:0] exp_d;
        cnt = 0; clr_next = 0; prev_clr = 0; prev_busy = 0; prev_trmt = 0;
        u_if.tx_done = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                u_if.tx_done = 1'b1;
                cnt = 0; clr_next = 0; tx_busy = 0;
                prev_clr = 0; prev_busy = 0; prev_trmt = 0;
            end else begin
                if (clr_next) begin
                    u_if.tx_done = 1'b0;
                    clr_next = 0;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        u_if.tx_done = 1'b1;
                        tx_busy = 0;
                    end
                end
                if (prev_clr) check("trmt_latency", u_if.trmt, 1'b1);
                if (u_if.trmt) begin
                    trmt_cnt++;
                    check("trmt_overlap", tx_busy, 1'b0);
                    check("trmt_pulse_len", prev_trmt, 1'b0);
                    if (rsp_q.size() == 0) begin
                        check("trmt_unexpected", rsp_q.size(), 1);
                    end else begin
                        exp_b = rsp_q.pop_front();
                        check("tx_data", u_if.tx_data, exp_b);
                    end
                    tx_busy = 1; clr_next = 1; cnt = TX_LAT;
                end
                if (u_if.clr_cmd_rdy) begin
                    clr_cnt++;
                    check("clr_while_tx", tx_busy, 1'b0);
                    u_if.cmd_rdy = 1'b0;
                end
                if (cfg_wr) begin
                    check("cfg_wr_with_trmt", u_if.trmt, 1'b1);
                    if (wa_q.size() == 0) begin
                        check("cfg_wr_unexpected", wa_q.size(), 1);
                    end else begin
                        exp_a = wa_q.pop_front();
                        exp_d = wd_q.pop_front();
                        check("cfg_wr_addr", cfg_wr_addr, exp_a);
                        check("cfg_wr_value", cfg_obs[cfg_wr_addr], exp_d);
                    end
                end
                if (prev_busy && !busy) check("busy_drop_txdone", {u_if.tx_done, tx_busy}, 2'b10);
                prev_clr  = u_if.clr_cmd_rdy;
                prev_busy = busy;
                prev_trmt = u_if.trmt;
            end
        end
    end

    // Queue the expected replies/writes, then present the command.
    task automatic issue(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d);
        int n;
        logic [1:0] ai;
        n = 0;
        while (u_if.cmd_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("issue_wait", u_if.cmd_rdy, 1'b0);
        ai = a[1:0];
        if (a < 8'd4 && op == 8'h01) begin
            rsp_q.push_back(ACK);
            cfg_m[ai] = d;
            wa_q.push_back(ai);
            wd_q.push_back(d);
            n_byte++;
        end else if (a < 8'd4 && op == 8'h02) begin
            rsp_q.push_back(cfg_m[ai]);
            n_byte++;
        end else if (a < 8'd4 && op == 8'h03) begin
            rsp_q.push_back(cfg_m[ai]);
            rsp_q.push_back(cfg_m[ai + 2'd1]);
            n_byte += 2;
        end else begin
            rsp_q.push_back(NAK);
            n_byte++;
        end
        n_cmd++;
        @(negedge clk);
        u_if.cmd = {op, a, d};
        u_if.cmd_rdy = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((u_if.cmd_rdy || busy || tx_busy) && n < 300);
        check(tag, {u_if.cmd_rdy, busy, tx_busy}, 3'b000);
        for (int i = 0; i < 4; i++) check($sformatf("%s_cfg%0d", tag, i), cfg_obs[i], cfg_m[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_trmt"}, u_if.trmt, 1'b0);
        check({tag, "_clr"}, u_if.clr_cmd_rdy, 1'b0);
        check({tag, "_cfg_wr"}, cfg_wr, 1'b0);
        check({tag, "_tx_data"}, u_if.tx_data, 8'h00);
        check({tag, "_wr_addr"}, cfg_wr_addr, 2'd0);
        for (int i = 0; i < 4; i++) check($sformatf("%s_cfg%0d", tag, i), cfg_obs[i], CRST);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int n;
        int t0;
        u_if.cmd_rdy = 1'b0;
        u_if.cmd     = 24'd0;
        for (int i = 0; i < 4; i++) cfg_m[i] = CRST;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Write, then read back.
        issue(8'h01, 8'h02, 8'h5A);
        wait_done("write_a2");
        issue(8'h02, 8'h02, 8'h00);
        wait_done("read_a2");

        // READ2 wrapping from 3 to 0.
        issue(8'h01, 8'h03, 8'h11);
        wait_done("write_a3");
        issue(8'h01, 8'h00, 8'h22);
        wait_done("write_a0");
        issue(8'h03, 8'h03, 8'h00);
        wait_done("read2_wrap");

        // Bad opcode, bad address.
        issue(8'h07, 8'h00, 8'h33);
        wait_done("bad_op");
        issue(8'h01, 8'h04, 8'h33);
        wait_done("bad_addr");

        // Second command pending during a READ2 reply.
        issue(8'h03, 8'h01, 8'h00);
        issue(8'h02, 8'h03, 8'h00);
        repeat (3) @(negedge clk);
        check("pending_held", {u_if.cmd_rdy, busy}, 2'b11);
        wait_done("pending_cmd");

        // Reset between the two READ2 bytes.
        t0 = trmt_cnt;
        issue(8'h03, 8'h00, 8'h00);
        n = 0;
        while (trmt_cnt == t0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("read2_first_byte", trmt_cnt - t0, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        n_byte -= rsp_q.size();
        rsp_q.delete();
        for (int i = 0; i < 4; i++) cfg_m[i] = CRST;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_trmt_after_rst", trmt_cnt - t0, 1);
        issue(8'h01, 8'h01, 8'h77);
        wait_done("write_after_rst");
        issue(8'h02, 8'h01, 8'h00);
        wait_done("read_after_rst");

        check("clr_total", clr_cnt, n_cmd);
        check("trmt_total", trmt_cnt, n_byte);
        check("replies_left", rsp_q.size(), 0);
        check("writes_left", wa_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_sequencer.md
UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

Interface
REQ-001 Parameter ACK_BYTE, default 8'hA5, reply byte for an accepted write.
REQ-002 Parameter NAK_BYTE, default 8'hEE, reply byte for a bad opcode or bad address.
REQ-003 Parameter CFG_RST, default 8'h00, reset value of all four config registers.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 cmd_rdy  input  1  transceiver holds high while a complete 24-bit command is pending.
REQ-007 cmd  input  24  pending command: [23:16] opcode, [15:8] address, [7:0] data.
REQ-008 clr_cmd_rdy  output  1  one-cycle pulse that clears cmd_rdy in the transceiver.
REQ-009 trmt  output  1  one-cycle pulse that starts transmission of tx_data.
REQ-010 tx_data  output  8  reply byte; stable from trmt until tx_done.
REQ-011 tx_done  input  1  high once the transceiver has finished the current byte; cleared by the transceiver on trmt.
REQ-012 cfg0, cfg1, cfg2, cfg3  output  8 each  config registers driving the capture datapath.
REQ-013 cfg_wr  output  1  one-cycle pulse, coincident with the register update.
REQ-014 cfg_wr_addr  output  2  index of the register written on cfg_wr.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, EXEC, WAIT_TX, all outputs registered.
- IDLE with cmd_rdy=1: latch cmd into cmd_q; clr_cmd_rdy high the next cycle; go to EXEC.
REQ-017 EXEC SHALL decode cmd_q and, at its closing edge, load tx_data, assert trmt for exactly one cycle, and go to WAIT_TX.
- First trmt is 2 cycles after the edge that samples cmd_rdy.
REQ-018 Opcode 8'h01 (WRITE) with address 0-3 SHALL update cfg[addr] <= data, pulse cfg_wr with cfg_wr_addr=addr in the trmt cycle, and reply ACK_BYTE.
REQ-019 Opcode 8'h02 (READ) with address 0-3 SHALL reply cfg[addr] (value before any write in the same cycle; none is possible).
REQ-020 Opcode 8'h03 (READ2) with address 0-3 SHALL reply cfg[addr] then cfg[(addr+1) mod 4]; address 3 wraps to 0.
REQ-021 Any other opcode, or address > 3 with any opcode, SHALL reply NAK_BYTE with no register change and no cfg_wr.
REQ-022 WAIT_TX SHALL ignore tx_done during the trmt cycle and the cycle after it.
- On a later tx_done=1: if a second READ2 byte is pending, load it, pulse trmt, stay in WAIT_TX (guard rule applies again); otherwise go to IDLE.
REQ-023 cmd_rdy asserted while busy SHALL be left uncleared and serviced on return to IDLE.
- IDLE SHALL sample cmd_rdy no earlier than the cycle after entry, giving at least one idle cycle between commands.
REQ-024 clr_cmd_rdy SHALL pulse exactly once per accepted command; trmt exactly once per reply byte.
REQ-025 tx_done arriving in IDLE or EXEC SHALL be ignored.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, with:
- clr_cmd_rdy=0, trmt=0, cfg_wr=0, busy=0
- tx_data=8'h00, cfg_wr_addr=0, cfg0-3=CFG_RST, second-byte flag cleared
REQ-027 Reset mid-transfer SHALL abandon the reply with no further trmt; the first command after release SHALL be handled normally.

Verification
REQ-028 cmd=24'h01_02_5A, cmd_rdy -> clr_cmd_rdy pulse; cfg2=8'h5A; cfg_wr with addr 2; trmt with tx_data=8'hA5; after tx_done, busy=0.
REQ-029 After REQ-028, cmd=24'h02_02_00 -> single trmt with tx_data=8'h5A; cfg unchanged.
REQ-030 cfg3=8'h11, cfg0=8'h22, cmd=24'h03_03_00 -> two trmt pulses, tx_data 8'h11 then 8'h22, second only after first tx_done.
REQ-031 cmd=24'h07_00_33 and cmd=24'h01_04_33 -> each replies 8'hEE; no cfg_wr; registers unchanged.
REQ-032 Second command pending (cmd_rdy held) during a READ2 reply -> not cleared until IDLE, then processed; exactly one clr_cmd_rdy per command.
REQ-033 rst_n pulsed low between the two READ2 bytes -> outputs at reset values immediately; no second trmt; next WRITE works.
